// File: rtl/nco_out_pkg.sv
// Shared constants, types and helpers for the NCO serial output sequencer.
package nco_out_pkg;

  localparam int CHUNK_W  = 2;
  localparam int WORD_W   = 12;
  localparam int N_CHUNKS = 6;
  localparam int VLD_LAT  = 7;
  localparam int SAMPLE_W = 2 * WORD_W + 1;

  // A SIGN frame only updates the terminal's sign register; a DATA frame carries a sample.
  typedef enum logic {
    FT_SIGN = 1'b0,
    FT_DATA = 1'b1
  } frame_type_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RDY   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_WAITV = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  typedef struct packed {
    logic              inv;
    logic [WORD_W-1:0] x;
    logic [WORD_W-1:0] y;
  } sample_t;

  // Select 2-bit chunk k of a word, LSB-first.
  function automatic logic [CHUNK_W-1:0] chunk_of(input logic [WORD_W-1:0] w,
                                                  input logic [2:0]        k);
    logic [WORD_W-1:0] sh;
    sh = w >> {k, 1'b0};
    return sh[CHUNK_W-1:0];
  endfunction

endpackage

// File: rtl/nco_out_fifo.sv
// Small first-word-fall-through sample FIFO between the NCO core and the frame sequencer.
module nco_out_fifo
  import nco_out_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    i_push,
  input  sample_t i_data,
  input  logic    i_pop,
  output sample_t o_head,
  output logic    o_full,
  output logic    o_empty
);

  localparam int AW = $clog2(DEPTH);

  sample_t       r_mem [DEPTH];
  logic [AW:0]   r_wr;
  logic [AW:0]   r_rd;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd[AW-1:0]];

  // Pointers carry one extra wrap bit so full and empty are distinguishable; reset flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + {{AW{1'b0}}, 1'b1};
      if (w_do_pop)  r_rd <= r_rd + {{AW{1'b0}}, 1'b1};
    end
  end

  // Sample storage; contents are meaningless until the write pointer covers them.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/nco_out_sequencer.sv
// Frame sequencer for the 2-bit serial output terminal: buffers NCO samples, inserts
// sign-set frames when the terminal's lagging sign register must change, shifts data
// LSB-first, and checks the terminal's Vld return.
module nco_out_sequencer
  import nco_out_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int FRAME_GAP = 8,
  parameter int CHUNKS    = N_CHUNKS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [WORD_W-1:0]  s_x,
  input  logic [WORD_W-1:0]  s_y,
  input  logic               s_inv,
  output logic               Rdy,
  output logic [CHUNK_W-1:0] Xin,
  output logic [CHUNK_W-1:0] Yin,
  output logic               ISin,
  input  logic               Vld,
  output logic               dout_strb,
  output logic               err,
  output logic [15:0]        frame_cnt
);

  localparam logic [3:0] GAP_LAST   = 4'(FRAME_GAP - 1);
  localparam logic [2:0] CHUNK_LAST = 3'(CHUNKS - 1);

  state_t            r_state;
  state_t            w_next;
  sample_t           w_head;
  sample_t           w_push_data;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_sign_mismatch;
  logic              w_gap_done;
  logic              w_in_waitv;
  logic [2:0]        r_chunk;
  logic [3:0]        r_gap;
  frame_type_t       r_ftype;
  logic              r_fsign;
  logic [WORD_W-1:0] r_fx;
  logic [WORD_W-1:0] r_fy;
  logic              r_is_m;
  logic              r_is_ok;
  logic              r_err;
  logic              r_dout_strb;
  logic [15:0]       r_frame_cnt;

  assign w_push_data = '{inv: s_inv, x: s_x, y: s_y};
  assign s_ready     = !w_full;

  nco_out_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (s_valid),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // The terminal's sign register must already hold the head's invert flag before a DATA
  // frame; an unknown mirror (after reset) always forces a SIGN frame first.
  assign w_sign_mismatch = !r_is_ok || (w_head.inv != r_is_m);
  assign w_pop           = (r_state == ST_RDY) && !w_sign_mismatch;
  assign w_in_waitv      = (r_state == ST_WAITV);
  // r_gap equals the number of cycles since the last Rdy (saturating).
  assign w_gap_done      = (r_gap >= GAP_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic. Once the gap has elapsed, WAITV/GAP pass straight through IDLE to
  // RDY when a sample is waiting, so back-to-back Rdy pulses are exactly FRAME_GAP apart
  // (for FRAME_GAP=8 the GAP state is skipped entirely).
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (!w_empty) w_next = ST_RDY;
      ST_RDY:   w_next = ST_SHIFT;
      ST_SHIFT: if (r_chunk == CHUNK_LAST) w_next = ST_WAITV;
      ST_WAITV,
      ST_GAP: begin
        if (w_gap_done) w_next = w_empty ? ST_IDLE : ST_RDY;
        else            w_next = ST_GAP;
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  // Terminal outputs. In RDY the frame register is not loaded yet, so ISin comes from the
  // head: a SIGN frame sends head.inv, and a DATA frame only happens when head.inv==is_m.
  always_comb begin
    Rdy  = 1'b0;
    Xin  = '0;
    Yin  = '0;
    ISin = 1'b0;
    case (r_state)
      ST_RDY: begin
        Rdy  = 1'b1;
        ISin = w_head.inv;
      end
      ST_SHIFT: begin
        Xin  = chunk_of(r_fx, r_chunk);
        Yin  = chunk_of(r_fy, r_chunk);
        ISin = r_fsign;
      end
      ST_WAITV: ISin = r_fsign;
      default: ;
    endcase
  end

  // Frame control: chunk index, gap counter and frame type/sign captured at Rdy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chunk <= '0;
      r_gap   <= '1;
      r_ftype <= FT_SIGN;
      r_fsign <= 1'b0;
    end else if (r_state == ST_RDY) begin
      r_chunk <= '0;
      r_gap   <= 4'd1;
      r_ftype <= w_sign_mismatch ? FT_SIGN : FT_DATA;
      r_fsign <= w_head.inv;
    end else begin
      if (r_state == ST_SHIFT) r_chunk <= r_chunk + 3'd1;
      if (r_gap != 4'hF)       r_gap   <= r_gap + 4'd1;
    end
  end

  // Frame payload; a SIGN frame shifts all-zero chunks.
  always_ff @(posedge clk) begin
    if (r_state == ST_RDY) begin
      r_fx <= w_sign_mismatch ? '0 : w_head.x;
      r_fy <= w_sign_mismatch ? '0 : w_head.y;
    end
  end

  // Vld check, sign mirror, result strobe and data-frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_m      <= 1'b0;
      r_is_ok     <= 1'b0;
      r_err       <= 1'b0;
      r_dout_strb <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      // Vld must be high exactly in WAITV and nowhere else.
      r_err       <= r_err | (w_in_waitv ^ Vld);
      r_dout_strb <= w_in_waitv && (r_ftype == FT_DATA);
      if (w_in_waitv && Vld) begin
        if (r_ftype == FT_DATA) begin
          r_frame_cnt <= r_frame_cnt + 16'd1;
        end else begin
          r_is_m  <= r_fsign;
          r_is_ok <= 1'b1;
        end
      end
    end
  end

  assign dout_strb = r_dout_strb;
  assign err       = r_err;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_nco_out_sequencer.sv
// Bench for nco_out_sequencer: directed scenarios plus a random sample stream, checked
// cycle by cycle against a frame-level reference model.
module tb_nco_out_sequencer;

  localparam int DEPTH = 2;
  localparam int FG    = 8;
  localparam int FG12  = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [11:0] s_x = '0;
  logic [11:0] s_y = '0;
  logic        s_inv = 1'b0;
  logic        Vld = 1'b0;
  logic        s_ready, Rdy, ISin, dout_strb, err;
  logic [1:0]  Xin, Yin;
  logic [15:0] frame_cnt;

  logic        s_valid12 = 1'b0;
  logic        Vld12 = 1'b0;
  logic        s_ready12, Rdy12, ISin12, dout12, err12;
  logic [1:0]  Xin12, Yin12;
  logic [15:0] fcnt12;

  always #5 clk = ~clk;

  nco_out_sequencer #(.DEPTH(DEPTH), .FRAME_GAP(FG)) u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y),
    .s_inv(s_inv), .Rdy(Rdy), .Xin(Xin), .Yin(Yin), .ISin(ISin), .Vld(Vld),
    .dout_strb(dout_strb), .err(err), .frame_cnt(frame_cnt)
  );

  nco_out_sequencer #(.DEPTH(DEPTH), .FRAME_GAP(FG12)) u_dut12 (
    .clk(clk), .rst(rst), .s_valid(s_valid12), .s_ready(s_ready12), .s_x(s_x), .s_y(s_y),
    .s_inv(1'b0), .Rdy(Rdy12), .Xin(Xin12), .Yin(Yin12), .ISin(ISin12), .Vld(Vld12),
    .dout_strb(dout12), .err(err12), .frame_cnt(fcnt12)
  );

  typedef struct {
    logic        inv;
    logic [11:0] x;
    logic [11:0] y;
  } smp_t;

  // Reference model state: queued samples, current frame, terminal sign mirror.
  smp_t        q[$];
  int          n, t_rdy, fidx, dout_at, wh_idx, stray_idx, fcnt, rdy_cnt;
  bit          is_m, is_ok, fdata, fsign, m_err, vdrv;
  logic [11:0] fx, fy, xcap, ycap;
  logic [7:0]  hist12;
  int          last12, gaps12;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    n = 0; t_rdy = -1000; fidx = -1; dout_at = -1000; fcnt = 0; rdy_cnt = 0;
    is_m = 0; is_ok = 0; fdata = 0; fsign = 0; m_err = 0; fx = '0; fy = '0;
    wh_idx = -1; stray_idx = -1; hist12 = '0; last12 = -1;
  endtask

  // One clock cycle: drive inputs, compare outputs at the falling edge, advance the model.
  task automatic cyc(input bit v, input logic [11:0] x, input logic [11:0] y,
                     input bit inv, output bit acc);
    int   off;
    smp_t h;
    s_valid = v; s_x = x; s_y = y; s_inv = inv;
    vdrv = ((n == t_rdy + 7) && (fidx != wh_idx)) ||
           ((n == t_rdy + 9) && (fidx == stray_idx));
    Vld   = vdrv;
    Vld12 = hist12[6];
    acc   = v && (q.size() < DEPTH);
    @(negedge clk);
    off = n - t_rdy;
    chk("rdy",   32'(Rdy),  32'(off == 0));
    chk("xin",   32'(Xin),  (off >= 1 && off <= 6) ? 32'(fx[2*(off-1) +: 2]) : 32'd0);
    chk("yin",   32'(Yin),  (off >= 1 && off <= 6) ? 32'(fy[2*(off-1) +: 2]) : 32'd0);
    chk("isin",  32'(ISin), (off >= 0 && off <= 7) ? 32'(fsign) : 32'd0);
    chk("dout",  32'(dout_strb), 32'(n == dout_at));
    chk("ready", 32'(s_ready), 32'(q.size() < DEPTH));
    chk("err",   32'(err), 32'(m_err));
    chk("fcnt",  32'(frame_cnt), 32'(fcnt));
    if (Rdy) rdy_cnt++;
    if (fdata && off >= 1 && off <= 6) begin
      xcap = {Xin, xcap[11:2]};
      ycap = {Yin, ycap[11:2]};
    end
    hist12 = {hist12[6:0], Rdy12};
    if (Rdy12) begin
      if (last12 >= 0) begin
        chk("gap12", 32'(n - last12), 32'(FG12));
        gaps12++;
      end
      last12 = n;
    end
    @(posedge clk);
    if (vdrv != (n == t_rdy + 7)) m_err = 1;
    if (n == t_rdy + 7) begin
      if (fdata) dout_at = n + 1;
      if (vdrv) begin
        if (fdata) fcnt++;
        else begin is_m = fsign; is_ok = 1; end
      end
    end
    if (n == t_rdy && fdata) void'(q.pop_front());
    if ((n + 1 >= t_rdy + FG) && q.size() > 0) begin
      h     = q[0];
      t_rdy = n + 1;
      fidx++;
      fdata = is_ok && (h.inv == is_m);
      fsign = h.inv;
      fx    = fdata ? h.x : 12'h000;
      fy    = fdata ? h.y : 12'h000;
    end
    if (acc) q.push_back('{inv: inv, x: x, y: y});
    #1;
    n++;
  endtask

  task automatic idle(input int k);
    bit a;
    for (int i = 0; i < k; i++) cyc(0, 12'h000, 12'h000, 1'b0, a);
  endtask

  task automatic push(input logic [11:0] x, input logic [11:0] y, input bit inv);
    bit a;
    a = 0;
    for (int i = 0; i < 200 && !a; i++) cyc(1, x, y, inv, a);
    total++;
    if (!a) begin
      bad++;
      $display("FAIL push_timeout observed=not_accepted expected=accepted");
    end
  endtask

  task automatic do_reset();
    rst = 1; s_valid = 0; Vld = 0; Vld12 = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_rdy",   32'(Rdy), 0);
    chk("rst_xy",    32'({Xin, Yin}), 0);
    chk("rst_isin",  32'(ISin), 0);
    chk("rst_dout",  32'(dout_strb), 0);
    chk("rst_err",   32'(err), 0);
    chk("rst_fcnt",  32'(frame_cnt), 0);
    chk("rst_ready", 32'(s_ready), 1);
    rst = 0;
    model_reset();
  endtask

  initial begin
    bit b;
    gaps12 = 0;
    xcap = '0; ycap = '0;
    model_reset();
    s_valid12 = 1;

    // Single sample after reset: SIGN frame then DATA frame.
    do_reset();
    push(12'h123, 12'hABC, 1'b0);
    idle(24);
    chk("t1_xseq", 32'(xcap), 32'h123);
    chk("t1_yseq", 32'(ycap), 32'hABC);
    chk("t1_fcnt", 32'(frame_cnt), 1);
    chk("t1_frames", 32'(rdy_cnt), 2);

    // Four back-to-back samples with the same sign.
    do_reset();
    for (int i = 0; i < 4; i++) push(12'($urandom), 12'($urandom), 1'b0);
    idle(50);
    chk("t2_frames", 32'(rdy_cnt), 5);
    chk("t2_fcnt", 32'(frame_cnt), 4);
    chk("t2_err", 32'(err), 0);

    // Sign changes force extra SIGN frames: S,D,S,D,D,S,D.
    do_reset();
    push(12'($urandom), 12'($urandom), 1'b0);
    push(12'($urandom), 12'($urandom), 1'b1);
    push(12'($urandom), 12'($urandom), 1'b1);
    push(12'($urandom), 12'($urandom), 1'b0);
    idle(70);
    chk("t3_frames", 32'(rdy_cnt), 7);
    chk("t3_fcnt", 32'(frame_cnt), 4);

    // Terminal withholds Vld on frame 2.
    do_reset();
    wh_idx = 2;
    for (int i = 0; i < 3; i++) push(12'($urandom), 12'($urandom), 1'b0);
    idle(50);
    chk("t4_err", 32'(err), 1);
    chk("t4_fcnt", 32'(frame_cnt), 2);

    // Stray Vld after the last frame.
    do_reset();
    stray_idx = 1;
    push(12'($urandom), 12'($urandom), 1'b1);
    idle(30);
    chk("t4b_err", 32'(err), 1);
    chk("t4b_fcnt", 32'(frame_cnt), 1);

    // Asynchronous reset during chunk 3 of a DATA frame.
    do_reset();
    push(12'hFFF, 12'hFFF, 1'b1);
    for (int i = 0; i < 100 && !(fidx == 1 && n - t_rdy == 4); i++)
      cyc(0, 12'h000, 12'h000, 1'b0, b);
    chk("t5_reached", 32'(fidx == 1 && n - t_rdy == 4), 1);
    #1 rst = 1; Vld = 0;
    #1;
    chk("t5_rdy",   32'(Rdy), 0);
    chk("t5_xin",   32'(Xin), 0);
    chk("t5_yin",   32'(Yin), 0);
    chk("t5_isin",  32'(ISin), 0);
    chk("t5_ready", 32'(s_ready), 1);
    chk("t5_err",   32'(err), 0);
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    push(12'h5A5, 12'h3C3, 1'b1);
    idle(24);
    chk("t5_frames", 32'(rdy_cnt), 2);
    chk("t5_fcnt", 32'(frame_cnt), 1);

    // Random sample stream with random spacing and sign changes.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      push(12'($urandom), 12'($urandom), 1'($urandom_range(0, 3) == 0));
      idle($urandom_range(0, 3));
    end
    idle(120);
    chk("rnd_fcnt", 32'(frame_cnt), 40);
    chk("rnd_err", 32'(err), 0);
    chk("rnd_empty", 32'(q.size()), 0);

    chk("g12_err", 32'(err12), 0);
    chk("g12_seen", 32'(gaps12 >= 10), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
